// File: rtl/mem_test_engine.sv
// Data-memory test initiator: FILL writes a linear pattern over an address range,
// CHECK reads it back and counts mismatches. One command per start strobe.
module mem_test_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] pattern,
    input  logic [DATA_W-1:0] incr,
    output logic              memwrite,
    output logic              memread,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              error
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W + 1)'(1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   pat_reg, pat_next;
    logic [DATA_W-1:0]   incr_reg, incr_next;
    logic [ADDR_W:0]     remaining_reg, remaining_next;
    logic                memwrite_reg, memwrite_next;
    logic                memread_reg, memread_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic [ADDR_W:0]     err_count_reg, err_count_next;
    logic [ADDR_W-1:0]   first_err_reg, first_err_next;
    logic                error_reg, error_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            pat_reg       <= '0;
            incr_reg      <= '0;
            remaining_reg <= '0;
            memwrite_reg  <= 1'b0;
            memread_reg   <= 1'b0;
            wdata_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_count_reg <= '0;
            first_err_reg <= '0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            pat_reg       <= pat_next;
            incr_reg      <= incr_next;
            remaining_reg <= remaining_next;
            memwrite_reg  <= memwrite_next;
            memread_reg   <= memread_next;
            wdata_reg     <= wdata_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_count_reg <= err_count_next;
            first_err_reg <= first_err_next;
            error_reg     <= error_next;
        end
    end

    // Memory-side outputs are computed one cycle ahead so the registered copies
    // line up with the access cycle they belong to.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        pat_next       = pat_reg;
        incr_next      = incr_reg;
        remaining_next = remaining_reg;
        memwrite_next  = 1'b0;
        memread_next   = 1'b0;
        wdata_next     = '0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        err_count_next = err_count_reg;
        first_err_next = first_err_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    addr_next      = base_addr;
                    pat_next       = pattern;
                    incr_next      = incr;
                    remaining_next = length;
                    err_count_next = '0;
                    first_err_next = '0;
                    if (length == '0) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end else if (!mode) begin
                        state_next    = S_FILL;
                        memwrite_next = 1'b1;
                        wdata_next    = pattern;
                        busy_next     = 1'b1;
                    end else begin
                        state_next   = S_CHECK;
                        memread_next = 1'b1;
                        busy_next    = 1'b1;
                    end
                end
            end
            S_FILL, S_CHECK: begin
                addr_next      = addr_reg + ONE_ADDR;
                pat_next       = pat_reg + incr_reg;
                remaining_next = remaining_reg - ONE_CNT;
                if (state_reg == S_CHECK && read_data != pat_reg) begin
                    err_count_next = err_count_reg + ONE_CNT;
                    if (err_count_reg == '0)
                        first_err_next = addr_reg;
                end
                if (remaining_reg == ONE_CNT) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    busy_next = 1'b1;
                    if (state_reg == S_FILL) begin
                        memwrite_next = 1'b1;
                        wdata_next    = pat_reg + incr_reg;
                    end else begin
                        memread_next = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        error_next = (err_count_next != '0);
    end

    assign memwrite       = memwrite_reg;
    assign memread        = memread_reg;
    assign address        = addr_reg;
    assign write_data     = wdata_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign err_count      = err_count_reg;
    assign first_err_addr = first_err_reg;
    assign error          = error_reg;

endmodule
